// File: rtl/pebb_pkg.sv
// Types and default header field positions shared by packet_sender and the packet buffer.
package pebb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } sender_state_t;

    localparam int DEF_FLIT_SIZE         = 64;
    localparam int DEF_TO_ADDRESS_MSB    = 63;
    localparam int DEF_TO_ADDRESS_LSB    = 56;
    localparam int DEF_FROM_ADDRESS_MSB  = 55;
    localparam int DEF_FROM_ADDRESS_LSB  = 48;
    localparam int DEF_PACKET_LENGTH_MSB = 47;
    localparam int DEF_PACKET_LENGTH_LSB = 40;

endpackage

// File: rtl/header_pack.sv
// Combinational header flit assembly: address and length fields placed, every other bit zero.
module header_pack #(
    parameter int FLIT_SIZE         = pebb_pkg::DEF_FLIT_SIZE,
    parameter int TO_ADDRESS_MSB    = pebb_pkg::DEF_TO_ADDRESS_MSB,
    parameter int TO_ADDRESS_LSB    = pebb_pkg::DEF_TO_ADDRESS_LSB,
    parameter int FROM_ADDRESS_MSB  = pebb_pkg::DEF_FROM_ADDRESS_MSB,
    parameter int FROM_ADDRESS_LSB  = pebb_pkg::DEF_FROM_ADDRESS_LSB,
    parameter int PACKET_LENGTH_MSB = pebb_pkg::DEF_PACKET_LENGTH_MSB,
    parameter int PACKET_LENGTH_LSB = pebb_pkg::DEF_PACKET_LENGTH_LSB
) (
    input  logic [TO_ADDRESS_MSB-TO_ADDRESS_LSB:0]       to_addr,
    input  logic [FROM_ADDRESS_MSB-FROM_ADDRESS_LSB:0]   from_addr,
    input  logic [PACKET_LENGTH_MSB-PACKET_LENGTH_LSB:0] length,
    output logic [FLIT_SIZE-1:0]                         flit
);

    always_comb begin
        flit = '0;
        flit[TO_ADDRESS_MSB:TO_ADDRESS_LSB]       = to_addr;
        flit[FROM_ADDRESS_MSB:FROM_ADDRESS_LSB]   = from_addr;
        flit[PACKET_LENGTH_MSB:PACKET_LENGTH_LSB] = length;
    end

endmodule

// File: rtl/packet_sender.sv
// Turns a packet command plus a stream of body flits into header+body flits through one
// output register; IDLE waits for a command, BODY forwards the remaining payload flits.
module packet_sender
    import pebb_pkg::*;
#(
    parameter int FLIT_SIZE         = DEF_FLIT_SIZE,
    parameter int TO_ADDRESS_MSB    = DEF_TO_ADDRESS_MSB,
    parameter int TO_ADDRESS_LSB    = DEF_TO_ADDRESS_LSB,
    parameter int FROM_ADDRESS_MSB  = DEF_FROM_ADDRESS_MSB,
    parameter int FROM_ADDRESS_LSB  = DEF_FROM_ADDRESS_LSB,
    parameter int PACKET_LENGTH_MSB = DEF_PACKET_LENGTH_MSB,
    parameter int PACKET_LENGTH_LSB = DEF_PACKET_LENGTH_LSB
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cmd_valid,
    output logic                                         cmd_ready,
    input  logic [TO_ADDRESS_MSB-TO_ADDRESS_LSB:0]       cmd_to_addr,
    input  logic [FROM_ADDRESS_MSB-FROM_ADDRESS_LSB:0]   cmd_from_addr,
    input  logic [PACKET_LENGTH_MSB-PACKET_LENGTH_LSB:0] cmd_length,
    output logic                                         cmd_error,
    input  logic [FLIT_SIZE-1:0]                         pay_flit,
    input  logic                                         pay_valid,
    output logic                                         pay_ready,
    output logic [FLIT_SIZE-1:0]                         out_flit,
    output logic                                         out_flit_valid,
    input  logic                                         out_ready,
    output logic                                         busy,
    output logic [7:0]                                   n_sent,
    output sender_state_t                                dbg_state
);

    localparam int LEN_W = PACKET_LENGTH_MSB - PACKET_LENGTH_LSB + 1;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    sender_state_t        state;
    logic [LEN_W-1:0]     remaining;
    logic [FLIT_SIZE-1:0] header_flit;
    logic                 out_free;
    logic                 cmd_fire;
    logic                 pay_fire;

    header_pack #(
        .FLIT_SIZE        (FLIT_SIZE),
        .TO_ADDRESS_MSB   (TO_ADDRESS_MSB),
        .TO_ADDRESS_LSB   (TO_ADDRESS_LSB),
        .FROM_ADDRESS_MSB (FROM_ADDRESS_MSB),
        .FROM_ADDRESS_LSB (FROM_ADDRESS_LSB),
        .PACKET_LENGTH_MSB(PACKET_LENGTH_MSB),
        .PACKET_LENGTH_LSB(PACKET_LENGTH_LSB)
    ) u_header_pack (
        .to_addr  (cmd_to_addr),
        .from_addr(cmd_from_addr),
        .length   (cmd_length),
        .flit     (header_flit)
    );

    // Every channel transfers exactly on a posedge where valid && ready are both high;
    // valid never waits on ready, and the held flit stays put while out_flit_valid && !out_ready.
    assign out_free  = !out_flit_valid || out_ready;
    assign cmd_ready = !rst && (state == IDLE) && out_free;
    assign pay_ready = !rst && (state == BODY) && out_free;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign pay_fire  = pay_valid && pay_ready;
    assign busy      = (state == BODY);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            remaining      <= '0;
            out_flit       <= '0;
            out_flit_valid <= 1'b0;
            n_sent         <= 8'd0;
            cmd_error      <= 1'b0;
        end else begin
            cmd_error <= 1'b0;
            // Drop valid once the held flit is taken; any reload below overrides this.
            if (out_flit_valid && out_ready) begin
                out_flit_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_length == '0) begin
                            cmd_error <= 1'b1;
                        end else begin
                            out_flit       <= header_flit;
                            out_flit_valid <= 1'b1;
                            remaining      <= cmd_length - LEN_ONE;
                            if (cmd_length == LEN_ONE) begin
                                n_sent <= n_sent + 8'd1;
                            end else begin
                                state <= BODY;
                            end
                        end
                    end
                end
                BODY: begin
                    if (pay_fire) begin
                        out_flit       <= pay_flit;
                        out_flit_valid <= 1'b1;
                        remaining      <= remaining - LEN_ONE;
                        if (remaining == LEN_ONE) begin
                            state  <= IDLE;
                            n_sent <= n_sent + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_sender.sv
// Scenario bench for packet_sender: drivers push expected flits, a negedge monitor pops and compares.
module tb_packet_sender;
    import pebb_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_to_addr;
    logic [7:0]    cmd_from_addr;
    logic [7:0]    cmd_length;
    logic          cmd_error;
    logic [63:0]   pay_flit;
    logic          pay_valid;
    logic          pay_ready;
    logic [63:0]   out_flit;
    logic          out_flit_valid;
    logic          out_ready;
    logic          busy;
    logic [7:0]    n_sent;
    sender_state_t dbg_state;

    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    logic [63:0] exp_q[$];
    int          cyc_q[$];
    bit          rand_mode = 1'b0;

    packet_sender dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_to_addr   (cmd_to_addr),
        .cmd_from_addr (cmd_from_addr),
        .cmd_length    (cmd_length),
        .cmd_error     (cmd_error),
        .pay_flit      (pay_flit),
        .pay_valid     (pay_valid),
        .pay_ready     (pay_ready),
        .out_flit      (out_flit),
        .out_flit_valid(out_flit_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .n_sent        (n_sent),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs only change #1 after posedge, so what is seen here is what the next edge commits.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && out_flit_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_flit_unexpected: got %h, expected nothing", out_flit);
            end else begin
                e = exp_q.pop_front();
                if (out_flit !== e) begin
                    failures++;
                    $display("FAIL out_flit: got %h, expected %h", out_flit, e);
                end
            end
            cyc_q.push_back(cycle);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic send_cmd(input logic [7:0] to, input logic [7:0] from, input logic [7:0] len);
        bit done = 1'b0;
        int n = 0;
        cmd_valid     = 1'b1;
        cmd_to_addr   = to;
        cmd_from_addr = from;
        cmd_length    = len;
        while (!done) begin
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (cmd_ready) begin
                done = 1'b1;
                if (len != 8'd0) exp_q.push_back({to, from, len, 40'h0});
            end
            tick();
            n++;
            if (!done && n > 50) begin
                checks++;
                failures++;
                $display("FAIL cmd_timeout: cmd_ready=%b, expected 1 within 50 cycles", cmd_ready);
                done = 1'b1;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic send_pay(input logic [63:0] d);
        bit done = 1'b0;
        int n = 0;
        pay_valid = 1'b1;
        pay_flit  = d;
        while (!done) begin
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (pay_ready) begin
                done = 1'b1;
                exp_q.push_back(d);
            end
            tick();
            n++;
            if (!done && n > 50) begin
                checks++;
                failures++;
                $display("FAIL pay_timeout: pay_ready=%b, expected 1 within 50 cycles", pay_ready);
                done = 1'b1;
            end
        end
        pay_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d flits outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_length = 8'd3; pay_valid = 1'b1; out_ready = 1'b1;
        cmd_to_addr = 8'h01; cmd_from_addr = 8'h02; pay_flit = 64'hdead;
        tick();
        tick();
        @(negedge clk);
        checks += 8;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready: got %b, expected 0", cmd_ready); end
        if (pay_ready !== 1'b0) begin failures++; $display("FAIL rst_pay_ready: got %b, expected 0", pay_ready); end
        if (out_flit_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b, expected 0", out_flit_valid); end
        if (out_flit !== 64'h0) begin failures++; $display("FAIL rst_out_flit: got %h, expected 0", out_flit); end
        if (n_sent !== 8'd0) begin failures++; $display("FAIL rst_n_sent: got %0d, expected 0", n_sent); end
        if (cmd_error !== 1'b0) begin failures++; $display("FAIL rst_cmd_error: got %b, expected 0", cmd_error); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        if (dbg_state !== IDLE) begin failures++; $display("FAIL rst_state: got %0d, expected IDLE", dbg_state); end
        @(posedge clk);
        #1;
        rst = 1'b0; cmd_valid = 1'b0; pay_valid = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] base = n_sent;
        cyc_q.delete();
        send_cmd(8'h12, 8'h34, 8'd3);
        checks += 2;
        if (out_flit !== 64'h1234_0300_0000_0000) begin failures++; $display("FAIL basic_header: got %h, expected 1234030000000000", out_flit); end
        if (out_flit_valid !== 1'b1) begin failures++; $display("FAIL basic_header_valid: got %b, expected 1", out_flit_valid); end
        send_pay(64'haaaa_0000_0000_000a);
        send_pay(64'hbbbb_0000_0000_000b);
        drain();
        checks += 2;
        if (cyc_q.size() != 3 || cyc_q[1] != cyc_q[0] + 1 || cyc_q[2] != cyc_q[1] + 1) begin
            failures++; $display("FAIL basic_consecutive: got %0d flits not on consecutive cycles, expected 3 back to back", cyc_q.size());
        end
        if (n_sent !== base + 8'd1) begin failures++; $display("FAIL basic_n_sent: got %0d, expected %0d", n_sent, base + 8'd1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] base = n_sent;
        cyc_q.delete();
        send_cmd(8'h21, 8'h43, 8'd1);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_len1: got %b, expected 0", busy); end
        send_cmd(8'h55, 8'h66, 8'd2);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_len2: got %b, expected 1", busy); end
        send_pay(64'hc0c0_c0c0_c0c0_c0c0);
        drain();
        checks += 2;
        if (cyc_q.size() != 3 || cyc_q[1] != cyc_q[0] + 1 || cyc_q[2] != cyc_q[1] + 1) begin
            failures++; $display("FAIL b2b_consecutive: got %0d flits not on consecutive cycles, expected 3 back to back", cyc_q.size());
        end
        if (n_sent !== base + 8'd2) begin failures++; $display("FAIL b2b_n_sent: got %0d, expected %0d", n_sent, base + 8'd2); end
    endtask

    task automatic test_stall();
        logic [7:0]  base = n_sent;
        logic [63:0] p1 = 64'h1111_2222_3333_4444;
        send_cmd(8'h0a, 8'h0b, 8'd4);
        send_pay(p1);
        out_ready = 1'b0;
        pay_valid = 1'b1;
        pay_flit  = 64'h5555_6666_7777_8888;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 3;
            if (out_flit !== p1) begin failures++; $display("FAIL stall_hold_flit: got %h, expected %h", out_flit, p1); end
            if (out_flit_valid !== 1'b1) begin failures++; $display("FAIL stall_hold_valid: got %b, expected 1", out_flit_valid); end
            if (pay_ready !== 1'b0) begin failures++; $display("FAIL stall_pay_ready: got %b, expected 0", pay_ready); end
            tick();
        end
        out_ready = 1'b1;
        send_pay(64'h5555_6666_7777_8888);
        send_pay(64'h9999_aaaa_bbbb_cccc);
        drain();
        checks++;
        if (n_sent !== base + 8'd1) begin failures++; $display("FAIL stall_n_sent: got %0d, expected %0d", n_sent, base + 8'd1); end
    endtask

    task automatic test_zero_len();
        logic [7:0] base;
        idle(3);
        base = n_sent;
        send_cmd(8'h77, 8'h88, 8'd0);
        checks += 2;
        if (cmd_error !== 1'b1) begin failures++; $display("FAIL zero_err_pulse: got %b, expected 1", cmd_error); end
        if (out_flit_valid !== 1'b0) begin failures++; $display("FAIL zero_out_valid: got %b, expected 0", out_flit_valid); end
        tick();
        checks += 3;
        if (cmd_error !== 1'b0) begin failures++; $display("FAIL zero_err_clear: got %b, expected 0", cmd_error); end
        if (out_flit_valid !== 1'b0) begin failures++; $display("FAIL zero_out_valid2: got %b, expected 0", out_flit_valid); end
        if (n_sent !== base) begin failures++; $display("FAIL zero_n_sent: got %0d, expected %0d", n_sent, base); end
    endtask

    task automatic test_idle_payload();
        pay_valid = 1'b1;
        pay_flit  = 64'hbad0_bad0_bad0_bad0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 2;
            if (pay_ready !== 1'b0) begin failures++; $display("FAIL idle_pay_ready: got %b, expected 0", pay_ready); end
            if (out_flit_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid: got %b, expected 0", out_flit_valid); end
            tick();
        end
        pay_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        send_cmd(8'h3c, 8'h4d, 8'd5);
        send_pay(64'hfeed_0000_0000_0001);
        @(negedge clk);
        tick();
        rst = 1'b1;
        pay_valid = 1'b1;
        @(negedge clk);
        checks += 2;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL mrst_cmd_ready: got %b, expected 0", cmd_ready); end
        if (pay_ready !== 1'b0) begin failures++; $display("FAIL mrst_pay_ready: got %b, expected 0", pay_ready); end
        tick();
        rst = 1'b0;
        pay_valid = 1'b0;
        checks += 5;
        if (out_flit_valid !== 1'b0) begin failures++; $display("FAIL mrst_out_valid: got %b, expected 0", out_flit_valid); end
        if (busy !== 1'b0) begin failures++; $display("FAIL mrst_busy: got %b, expected 0", busy); end
        if (dbg_state !== IDLE) begin failures++; $display("FAIL mrst_state: got %0d, expected IDLE", dbg_state); end
        if (n_sent !== 8'd0) begin failures++; $display("FAIL mrst_n_sent: got %0d, expected 0", n_sent); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL mrst_outstanding: got %0d flits, expected 0", exp_q.size()); end
        send_cmd(8'h9a, 8'hbc, 8'd2);
        send_pay(64'h0123_4567_89ab_cdef);
        drain();
        checks++;
        if (n_sent !== 8'd1) begin failures++; $display("FAIL mrst_new_n_sent: got %0d, expected 1", n_sent); end
    endtask

    task automatic test_random();
        logic [7:0] base = n_sent;
        int len;
        rand_mode = 1'b1;
        for (int p = 0; p < 8; p++) begin
            len = $urandom_range(1, 5);
            send_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'(len));
            for (int b = 1; b < len; b++) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
                send_pay({$urandom, $urandom});
            end
        end
        rand_mode = 1'b0;
        drain();
        checks++;
        if (n_sent !== base + 8'd8) begin failures++; $display("FAIL rand_n_sent: got %0d, expected %0d", n_sent, base + 8'd8); end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_to_addr = '0; cmd_from_addr = '0; cmd_length = '0;
        pay_valid = 1'b0; pay_flit = '0; out_ready = 1'b1; rst = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_zero_len();
        test_idle_payload();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/packet_sender.md
PACKET_SENDER -- requirements
Module: packet_sender

Interface
REQ-001 Parameters (name, default, meaning):
- FLIT_SIZE, 64, flit width in bits.
- TO_ADDRESS_MSB/LSB, 63/56, destination field in the header flit.
- FROM_ADDRESS_MSB/LSB, 55/48, source field in the header flit.
- PACKET_LENGTH_MSB/LSB, 47/40, length field, counted in flits including the header.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: the only clock; one clock; reset is synchronous and active-high.
- rst, in, 1: synchronous, active-high reset.
- cmd_valid, in, 1: packet command offered.
- cmd_ready, out, 1: command accepted when cmd_valid && cmd_ready at posedge.
- cmd_to_addr, in, TO width: destination address.
- cmd_from_addr, in, FROM width: source address.
- cmd_length, in, LENGTH width: total flits, header included.
- cmd_error, out, 1: one-cycle pulse when an illegal command is rejected.
- pay_flit, in, FLIT_SIZE: body flit.
- pay_valid, in, 1: body flit offered.
- pay_ready, out, 1: body flit accepted when pay_valid && pay_ready.
- out_flit, out, FLIT_SIZE: flit toward the packet buffer input.
- out_flit_valid, out, 1: out_flit valid.
- out_ready, in, 1: downstream takes the flit when out_flit_valid && out_ready.
- busy, out, 1: a packet is partially sent.
- n_sent, out, 8: count of completed packets, wraps modulo 256.

Function
REQ-003 States SHALL be IDLE and BODY.
REQ-004 The output register SHALL be free when !out_flit_valid || out_ready.
REQ-005 cmd_ready SHALL be high only when in IDLE and the output register is free; it is combinational.
REQ-006 On a command accept with cmd_length >= 1, the output register SHALL load the header flit on the same edge, and out_flit_valid SHALL be high on the next cycle.
- Header layout: to/from/length in their fields; all other bits 0.
REQ-007 On that accept, the block SHALL latch remaining = cmd_length-1, then go to BODY if remaining > 0, else stay in IDLE and increment n_sent.
REQ-008 On a command accept with cmd_length == 0, the block SHALL emit nothing, pulse cmd_error for one cycle, and stay in IDLE.
REQ-009 pay_ready SHALL be high only when in BODY and the output register is free.
- An accepted pay_flit SHALL load into out_flit unmodified, with 1-cycle latency.
- Each accept decrements remaining.
REQ-010 When the accept takes remaining from 1 to 0, the block SHALL go to IDLE and increment n_sent on that edge.
REQ-011 out_flit and out_flit_valid SHALL hold stable while out_flit_valid && !out_ready.
REQ-012 When the output register is not reloaded and the held flit is taken, out_flit_valid SHALL fall to 0.
REQ-013 Throughput SHALL be one flit per cycle with out_ready held high.
- The next packet's header SHALL directly follow the last body flit, with no bubble.
REQ-014 A payload stall (pay_valid low in BODY) SHALL produce bubbles (out_flit_valid low) without corrupting the flit count.
REQ-015 busy SHALL equal (state == BODY).
REQ-016 Payload offered while in IDLE SHALL NOT be accepted.
REQ-017 cmd_error SHALL NOT depend on out_ready.

Reset
REQ-018 When rst is high at posedge, the block SHALL set:
- state = IDLE, remaining = 0;
- out_flit_valid = 0, out_flit = 0;
- n_sent = 0, cmd_error = 0.
REQ-019 Reset mid-packet SHALL abandon the packet; no further flits of it are emitted, and n_sent is not incremented.
REQ-020 While rst is high, cmd_ready and pay_ready SHALL be 0.

Structure
REQ-021 The state enum and the default header field positions SHALL live in a shared package (pebb_pkg), also used by the packet buffer.
REQ-022 Header assembly SHALL be a combinational sub-module, header_pack (addresses + length -> flit).
- The state machine, counter, and output register remain in packet_sender.

Verification
REQ-023 Command to=0x12, from=0x34, length=3, payload A, B, out_ready=1 -> out_flit = 0x1234_03_0000000000, A, B on three consecutive cycles; n_sent=1.
REQ-024 length=1 command followed immediately by a length=2 command -> headers on consecutive cycles, then the body flit; n_sent=2; busy never high for the first packet.
REQ-025 length=4, out_ready low 3 cycles during the second flit -> that flit holds stable all 3 cycles; pay_ready low; no loss or duplication.
REQ-026 length=0 command -> cmd_error high exactly one cycle; out_flit_valid stays 0; n_sent unchanged.
REQ-027 rst asserted after the header and 1 body flit of a length=5 packet -> next cycle out_flit_valid=0, state IDLE, n_sent=0; a new length=2 packet then sends correctly.
